// File: rtl/halt_dump_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// halt_dump_ctrl_pkg
//   Shared CPU-side definitions for the halt / memory-dump controller:
//   - HALT_WORD: instruction encoding that stops the core. The fetch-stall
//     logic and the CPU bench use the same constant.
//   - Default data-memory geometry (ADDR_W / DEPTH) and drain length.
//   - Controller state encoding (6 states, 3 bits).
//   - cnt_width(): number of bits needed to hold a given maximum count.
// ---------------------------------------------------------------------------
package halt_dump_ctrl_pkg;

    localparam logic [31:0] HALT_WORD            = 32'hFFFF_FFFF;
    localparam int          DEFAULT_ADDR_W       = 9;
    localparam int          DEFAULT_DEPTH        = 512;
    localparam int          DEFAULT_DRAIN_CYCLES = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN       = 3'd0;
    localparam state_t ST_DRAIN     = 3'd1;
    localparam state_t ST_WAIT_SHOW = 3'd2;
    localparam state_t ST_READ      = 3'd3;
    localparam state_t ST_STREAM    = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

    // Bits needed to represent max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/halt_dump_ctrl_dump_addr_cnt.sv
// ---------------------------------------------------------------------------
// dump_addr_cnt
//   Counters owned by the halt/dump controller; the FSM lives in the parent.
//   - Drain counter: loads DRAIN_CYCLES-1, decrements on request, saturates
//     at 0. drain_zero flags the final drain cycle.
//   - Address counter: clears to 0, increments on request, never wraps.
//     addr_last flags the terminal address DEPTH-1; an increment request at
//     the terminal address is ignored so DEPTH = 2**ADDR_W ends at all-ones.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   drain_load   load drain counter with DRAIN_CYCLES-1
//   drain_dec    decrement drain counter (ignored at 0)
//   drain_zero   drain counter is 0
//   addr_clr     clear address counter
//   addr_inc     advance address counter (ignored at DEPTH-1)
//   addr         current word address
//   addr_last    addr == DEPTH-1
// ---------------------------------------------------------------------------
module dump_addr_cnt
    import halt_dump_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DEPTH        = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drain_load,
    input  logic              drain_dec,
    output logic              drain_zero,
    input  logic              addr_clr,
    input  logic              addr_inc,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_last
);

    localparam int                 DRAIN_W    = cnt_width(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);

    logic [DRAIN_W-1:0] drain_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (drain_load) begin
            drain_cnt <= DRAIN_INIT;
        end else if (drain_dec && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (addr_clr) begin
            addr <= '0;
        end else if (addr_inc && !addr_last) begin
            addr <= addr + 1'b1;
        end
    end

    assign drain_zero = (drain_cnt == '0);
    assign addr_last  = (addr == ADDR_LAST);

endmodule

// File: rtl/halt_dump_ctrl.sv
// ---------------------------------------------------------------------------
// halt_dump_ctrl
//   Watches the fetched instruction for HALT_WORD, stalls the core, holds
//   for DRAIN_CYCLES so in-flight stores retire, then waits for show_en and
//   streams every data-memory word (address 0 .. DEPTH-1) to the sink.
//
// Ports
//   CLK, RST_N    clock (rising edge), asynchronous active-low reset
//   instruction   fetched instruction, compared against HALT_WORD in RUN
//   show_en       level request to start the dump (sampled in WAIT_SHOW)
//   halted        1 in every state except RUN; stalls fetch/PC
//   mem_rd_en     data-memory read strobe (READ state only)
//   mem_rd_addr   word address of the read
//   mem_rd_data   read data, valid exactly one cycle after mem_rd_en
//   dump_valid    dump_data/dump_addr/dump_last are valid
//   dump_ready    sink accepts the word
//   dump_data     memory word
//   dump_addr     address of dump_data
//   dump_last     dump_data is the final word (address DEPTH-1)
//   done          dump complete, sticky until reset
//   state         current controller state (encoding in the package)
//
// Handshake: a word transfers on a rising edge where dump_valid and
// dump_ready are both 1. While dump_valid is 1 and no transfer has happened,
// dump_data, dump_addr and dump_last hold. dump_ready may be asserted at any
// time; it has no effect while dump_valid is 0. dump_valid does not depend
// on dump_ready.
// ---------------------------------------------------------------------------
module halt_dump_ctrl #(
    parameter logic [31:0] HALT_WORD    = halt_dump_ctrl_pkg::HALT_WORD,
    parameter int          DRAIN_CYCLES = halt_dump_ctrl_pkg::DEFAULT_DRAIN_CYCLES,
    parameter int          ADDR_W       = halt_dump_ctrl_pkg::DEFAULT_ADDR_W,
    parameter int          DEPTH        = halt_dump_ctrl_pkg::DEFAULT_DEPTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       instruction,
    input  logic              show_en,
    output logic              halted,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done,
    output logic [2:0]        state
);

    import halt_dump_ctrl_pkg::*;

    state_t              state_q;
    state_t              state_d;

    logic                drain_load;
    logic                drain_dec;
    logic                drain_zero;
    logic                addr_clr;
    logic                addr_inc;
    logic [ADDR_W-1:0]   addr;
    logic                addr_last;

    logic [ADDR_W-1:0]   dump_addr_q;
    logic                dump_last_q;
    logic [31:0]         held_q;
    logic                fresh_q;

    logic                handshake;

    dump_addr_cnt #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH)
    ) u_cnt (
        .clk        (CLK),
        .rst_n      (RST_N),
        .drain_load (drain_load),
        .drain_dec  (drain_dec),
        .drain_zero (drain_zero),
        .addr_clr   (addr_clr),
        .addr_inc   (addr_inc),
        .addr       (addr),
        .addr_last  (addr_last)
    );

    assign handshake = (state_q == ST_STREAM) && dump_ready;

    always_comb begin
        state_d    = state_q;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (instruction == HALT_WORD) begin
                    state_d    = ST_DRAIN;
                    drain_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Counter was loaded with DRAIN_CYCLES-1 on the halt edge,
                // so leaving on zero gives exactly DRAIN_CYCLES cycles here.
                if (drain_zero) begin
                    state_d = ST_WAIT_SHOW;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            ST_WAIT_SHOW: begin
                if (show_en) begin
                    state_d  = ST_READ;
                    addr_clr = 1'b1;
                end
            end
            ST_READ: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    if (dump_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_READ;
                        addr_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory read data arrives during the first STREAM cycle. It is shown
    // directly that cycle (fresh_q) and copied into held_q at the end of it,
    // so the word stays stable under backpressure even if the memory output
    // does not.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dump_addr_q <= '0;
            dump_last_q <= 1'b0;
            held_q      <= '0;
            fresh_q     <= 1'b0;
        end else begin
            fresh_q <= 1'b0;
            if (state_q == ST_READ) begin
                dump_addr_q <= addr;
                dump_last_q <= addr_last;
                fresh_q     <= 1'b1;
            end
            if (fresh_q) begin
                held_q <= mem_rd_data;
            end
        end
    end

    assign halted      = (state_q != ST_RUN);
    assign mem_rd_en   = (state_q == ST_READ);
    assign mem_rd_addr = addr;
    assign dump_valid  = (state_q == ST_STREAM);
    assign dump_data   = fresh_q ? mem_rd_data : held_q;
    assign dump_addr   = dump_addr_q;
    assign dump_last   = dump_valid && dump_last_q;
    assign done        = (state_q == ST_DONE);
    assign state       = state_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_halt_dump_ctrl
//   Directed bench for halt_dump_ctrl with DEPTH=8, ADDR_W=3, DRAIN_CYCLES=4.
//   Data memory is a synchronous-read model whose output is garbage on
//   cycles without a read strobe, so the controller must hold its word.
// ---------------------------------------------------------------------------
module tb_halt_dump_ctrl;

    import halt_dump_ctrl_pkg::*;

    localparam int ADDR_W       = 3;
    localparam int DEPTH        = 8;
    localparam int DRAIN_CYCLES = 4;
    localparam int W            = 1 + ADDR_W + 32;

    // ---------------- clock / reset ----------------
    logic              CLK;
    logic              RST_N;
    logic [31:0]       instruction;
    logic              show_en;
    logic              halted;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;
    logic              done;
    logic [2:0]        state;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    halt_dump_ctrl #(
        .HALT_WORD    (HALT_WORD),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .instruction (instruction),
        .show_en     (show_en),
        .halted      (halted),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .dump_last   (dump_last),
        .done        (done),
        .state       (state)
    );

    // ---------------- data memory model ----------------
    logic [31:0] mem [DEPTH];

    initial mem_rd_data = '0;
    always @(posedge CLK) begin
        mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 32'hDEAD_BEEF;
    end

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    int             hs_cnt   = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // A transfer happens on the next rising edge when valid and ready are
    // both high at the falling edge (inputs only change just after rising).
    always @(negedge CLK) begin
        if (RST_N && dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("hs_word", {dump_last, dump_addr, dump_data}, mon_exp);
            end
            hs_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_mem(input logic [31:0] base, input int n_push);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = base + 32'(i);
        end
        for (int i = 0; i < n_push; i++) begin
            exp_q.push_back({(i == DEPTH - 1), ADDR_W'(i), base + 32'(i)});
        end
    endtask

    task automatic wait_for(input logic [2:0] st, input logic [ADDR_W-1:0] a,
                            input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (state == st && (st != ST_READ || mem_rd_addr == a)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) check(tag, 64'd0, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_halted"}, 64'(halted),     64'd0);
        check({tag, "_rd_en"},  64'(mem_rd_en),  64'd0);
        check({tag, "_valid"},  64'(dump_valid), 64'd0);
        check({tag, "_data"},   64'(dump_data),  64'd0);
        check({tag, "_addr"},   64'(dump_addr),  64'd0);
        check({tag, "_last"},   64'(dump_last),  64'd0);
        check({tag, "_done"},   64'(done),       64'd0);
        check({tag, "_state"},  64'(state),      64'(ST_RUN));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST_N       = 1'b0;
        instruction = '0;
        show_en     = 1'b0;
        dump_ready  = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        RST_N = 1'b1;
        step();

        // Near miss: one bit short of the halt word.
        instruction = 32'hFFFF_FFFE;
        for (int i = 0; i < 10; i++) begin
            step();
            check("nearmiss_halted", 64'(halted), 64'd0);
        end
        check("nearmiss_state", 64'(state), 64'(ST_RUN));

        instruction = 32'h2008_0001;
        step();
        check("normal_halted", 64'(halted), 64'd0);

        // Halt at edge N, show_en raised two cycles later while draining.
        load_mem(32'hA000_0000, DEPTH);
        instruction = HALT_WORD;
        step();                                  // edge N
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_state",  64'(state),  64'(ST_DRAIN));
        instruction = '0;
        step();                                  // N+1
        step();                                  // N+2
        show_en = 1'b1;
        step();                                  // N+3
        check("drain_state", 64'(state),     64'(ST_DRAIN));
        check("drain_rd_en", 64'(mem_rd_en), 64'd0);
        step();                                  // N+4
        check("wait_state",  64'(state),     64'(ST_WAIT_SHOW));
        check("wait_rd_en",  64'(mem_rd_en), 64'd0);
        instruction = HALT_WORD;                 // ignored outside RUN
        dump_ready  = 1'b1;
        hs_cnt      = 0;
        step();                                  // N+5: first READ
        check("read0_rd_en", 64'(mem_rd_en),   64'd1);
        check("read0_addr",  64'(mem_rd_addr), 64'd0);

        repeat (15) step();
        check("dump_done_early", 64'(done), 64'd0);
        step();                                  // 16 cycles after first READ
        check("dump_done",       64'(done),         64'd1);
        check("dump_hs_cnt",     64'(hs_cnt),       64'd8);
        check("dump_exp_left",   64'(exp_q.size()), 64'd0);
        check("done_valid",      64'(dump_valid),   64'd0);
        check("done_halted",     64'(halted),       64'd1);
        repeat (3) step();
        check("done_sticky",     64'(state),        64'(ST_DONE));
        check("done_rd_en",      64'(mem_rd_en),    64'd0);

        // Second run: backpressure on word 3, reset during word 5.
        RST_N = 1'b0;
        step();
        RST_N       = 1'b1;
        instruction = '0;
        show_en     = 1'b0;
        dump_ready  = 1'b0;
        step();
        load_mem(32'hC000_0000, 5);
        hs_cnt      = 0;
        instruction = HALT_WORD;
        step();
        instruction = '0;
        show_en     = 1'b1;
        dump_ready  = 1'b1;
        wait_for(ST_READ, ADDR_W'(3), 40, "timeout_read3");
        dump_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(dump_valid), 64'd1);
            check("bp_data",  64'(dump_data),  64'h0000_0000_C000_0003);
            check("bp_addr",  64'(dump_addr),  64'd3);
            check("bp_rd_en", 64'(mem_rd_en),  64'd0);
            if (i < 4) step();
        end
        dump_ready = 1'b1;
        step();
        check("bp_next_rd_en", 64'(mem_rd_en),   64'd1);
        check("bp_next_addr",  64'(mem_rd_addr), 64'd4);
        wait_for(ST_READ, ADDR_W'(5), 10, "timeout_read5");
        dump_ready = 1'b0;
        step();
        check("w5_valid", 64'(dump_valid), 64'd1);
        check("w5_data",  64'(dump_data),  64'h0000_0000_C000_0005);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("rst_hs_cnt",   64'(hs_cnt),       64'd5);
        check("rst_exp_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step();
        RST_N = 1'b1;
        step();
        check("post_rst_state",  64'(state),  64'(ST_RUN));
        check("post_rst_halted", 64'(halted), 64'd0);

        // Restart from address 0 with new memory contents.
        load_mem(32'hB000_0000, DEPTH);
        hs_cnt      = 0;
        dump_ready  = 1'b1;
        instruction = HALT_WORD;
        step();
        instruction = '0;
        wait_for(ST_READ, ADDR_W'(0), 10, "timeout_restart");
        check("restart_addr", 64'(mem_rd_addr), 64'd0);
        wait_for(ST_DONE, '0, 40, "timeout_done2");
        check("restart_hs_cnt",   64'(hs_cnt),       64'd8);
        check("restart_exp_left", 64'(exp_q.size()), 64'd0);
        check("restart_done",     64'(done),         64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
